// File: rtl/usb_hosttrsac_pkg.sv
// usb_hosttrsac_pkg: PID, request-type and status codes plus FSM states for the host transaction engine
package usb_hosttrsac_pkg;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [1:0] REQ_OUT   = 2'd0;
    localparam logic [1:0] REQ_IN    = 2'd1;
    localparam logic [1:0] REQ_SETUP = 2'd2;
    localparam logic [1:0] REQ_RSV   = 2'd3;
    localparam logic [2:0] ST_ACK        = 3'd0;
    localparam logic [2:0] ST_NAK        = 3'd1;
    localparam logic [2:0] ST_STALL      = 3'd2;
    localparam logic [2:0] ST_TIMEOUT    = 3'd3;
    localparam logic [2:0] ST_ERR        = 3'd4;
    localparam logic [2:0] ST_DATA_OK    = 3'd5;
    localparam logic [2:0] ST_TOGGLE_ERR = 3'd6;
    typedef enum logic [3:0] {
        S_IDLE, S_TOK, S_TOK0, S_TOK1, S_DSTART, S_DATA,
        S_WAIT_HS, S_WAIT_DATA, S_RX_DATA, S_ACK, S_ACK_END, S_DONE
    } state_t;
endpackage

// File: rtl/usb_hosttrsac_crc5.sv
// usb_crc5: combinational USB token CRC5 over {endp,addr}, already ordered for token byte 2 bits [7:3]
module usb_crc5 (
    input  logic [10:0] d,
    output logic [4:0]  crc
);
    logic [4:0] c;
    always_comb begin
        c = 5'h1f;
        for (int i = 0; i < 11; i++)
            c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'h05 : 5'h00);
        crc = ~{c[0], c[1], c[2], c[3], c[4]};
    end
endmodule

// File: rtl/usb_hosttrsac.sv
// usb_hosttrsac: host-side USB FS transaction engine running one OUT/IN/SETUP per request.
// Define HOSTTRSAC_RETRY_EN to re-run NAK/TIMEOUT/ERR outcomes up to RETRY_MAX times (adds retry_cnt).
module usb_hosttrsac
    import usb_hosttrsac_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 18,
    parameter int DATA_MAXSIZE   = 64
`ifdef HOSTTRSAC_RETRY_EN
    , parameter int RETRY_MAX    = 3
`endif
) (
    input  logic       clk,
    input  logic       rst0_async,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [6:0] req_addr,
    input  logic [3:0] req_endp,
    input  logic       req_toggle,
    input  logic [7:0] txd_data,
    input  logic       txd_valid,
    input  logic       txd_last,
    output logic       txd_ready,
    output logic [7:0] rxd_data,
    output logic       rxd_valid,
    output logic       rxd_last,
    output logic       done,
    output logic [2:0] status,
    output logic [3:0] ptx_pid,
    output logic       ptx_start,
    output logic [7:0] ptx_data,
    output logic       ptx_valid,
    output logic       ptx_last,
    input  logic       ptx_ready,
    input  logic       prx_start,
    input  logic [3:0] prx_pid,
    input  logic [7:0] prx_data,
    input  logic       prx_valid,
    input  logic       prx_end,
    input  logic       prx_err
`ifdef HOSTTRSAC_RETRY_EN
    , output logic [1:0] retry_cnt
`endif
);
    state_t     state, state_d;
    logic [1:0] r_type;
    logic [6:0] r_addr;
    logic [3:0] r_endp;
    logic       r_tog;
    logic [4:0] crc5;
    logic [7:0] cnt, bcnt, rbuf;
    logic       buf_full, tog_err, fin, retry, tmo, is_data;
    logic [2:0] fin_st;
    logic [3:0] pid_tok, pid_dat;

    usb_crc5 u_crc5 (.d({r_endp, r_addr}), .crc(crc5));

    assign pid_tok = r_type == REQ_OUT ? PID_OUT : r_type == REQ_IN ? PID_IN : PID_SETUP;
    assign pid_dat = (r_type == REQ_SETUP || !r_tog) ? PID_DATA0 : PID_DATA1;
    assign tmo     = cnt == 8'(TIMEOUT_CYCLES);
    assign is_data = prx_pid == PID_DATA0 || prx_pid == PID_DATA1;

    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) state <= S_IDLE;
        else state <= state_d;

    always_comb begin
        state_d   = state;
        fin       = 1'b0;
        fin_st    = ST_ERR;
        retry     = 1'b0;
        req_ready = 1'b0;
        txd_ready = 1'b0;
        ptx_pid   = 4'd0;
        ptx_start = 1'b0;
        ptx_data  = 8'd0;
        ptx_valid = 1'b0;
        ptx_last  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = rst0_async;
                if (req_valid) begin
                    state_d = S_TOK;
                    fin     = req_type == REQ_RSV;
                end
            end
            S_TOK: begin
                ptx_start = 1'b1;
                ptx_pid   = pid_tok;
                state_d   = S_TOK0;
            end
            S_TOK0: begin
                ptx_pid   = pid_tok;
                ptx_valid = 1'b1;
                ptx_data  = {r_endp[0], r_addr};
                if (ptx_ready) state_d = S_TOK1;
            end
            S_TOK1: begin
                ptx_pid   = pid_tok;
                ptx_valid = 1'b1;
                ptx_last  = 1'b1;
                ptx_data  = {crc5, r_endp[3:1]};
                if (ptx_ready) state_d = r_type == REQ_IN ? S_WAIT_DATA : S_DSTART;
            end
            S_DSTART: begin
                ptx_start = 1'b1;
                ptx_pid   = pid_dat;
                state_d   = S_DATA;
            end
            S_DATA: begin
                // payload streams straight through; a txd_last without txd_valid is a zero-length packet
                ptx_pid   = pid_dat;
                txd_ready = ptx_ready;
                ptx_data  = txd_data;
                ptx_valid = txd_valid;
                ptx_last  = txd_last;
                if (txd_last && (ptx_ready || !txd_valid)) state_d = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                fin    = tmo || prx_err || prx_start;
                fin_st = tmo ? ST_TIMEOUT : prx_err ? ST_ERR : prx_pid == PID_ACK ? ST_ACK :
                         prx_pid == PID_NAK ? ST_NAK : prx_pid == PID_STALL ? ST_STALL : ST_ERR;
            end
            S_WAIT_DATA: begin
                fin    = tmo || prx_err || (prx_start && !is_data);
                fin_st = tmo ? ST_TIMEOUT : prx_err ? ST_ERR : prx_pid == PID_NAK ? ST_NAK :
                         prx_pid == PID_STALL ? ST_STALL : ST_ERR;
                if (prx_start && !fin) state_d = S_RX_DATA;
            end
            S_RX_DATA: begin
                fin = prx_err || (prx_valid && bcnt == 8'(DATA_MAXSIZE));
                if (prx_end && !fin) state_d = S_ACK;
            end
            S_ACK: begin
                ptx_start = 1'b1;
                ptx_pid   = PID_ACK;
                state_d   = S_ACK_END;
            end
            S_ACK_END: begin
                ptx_pid  = PID_ACK;
                ptx_last = 1'b1;
                fin      = 1'b1;
                fin_st   = tog_err ? ST_TOGGLE_ERR : ST_DATA_OK;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef HOSTTRSAC_RETRY_EN
        retry = fin && state != S_IDLE && 32'(retry_cnt) < RETRY_MAX &&
                (fin_st == ST_NAK || fin_st == ST_TIMEOUT || fin_st == ST_ERR);
`endif
        if (fin) state_d = retry ? S_TOK : S_DONE;
    end

    always_ff @(posedge clk or negedge rst0_async)
        if (!rst0_async) begin
            r_type    <= 2'd0;
            r_addr    <= 7'd0;
            r_endp    <= 4'd0;
            r_tog     <= 1'b0;
            cnt       <= 8'd0;
            bcnt      <= 8'd0;
            rbuf      <= 8'd0;
            buf_full  <= 1'b0;
            tog_err   <= 1'b0;
            status    <= 3'd0;
            rxd_data  <= 8'd0;
            rxd_valid <= 1'b0;
            rxd_last  <= 1'b0;
`ifdef HOSTTRSAC_RETRY_EN
            retry_cnt <= 2'd0;
`endif
        end else begin
            rxd_valid <= 1'b0;
            rxd_last  <= 1'b0;
            cnt       <= (state == S_WAIT_HS || state == S_WAIT_DATA) ? cnt + 8'd1 : 8'd0;
            if (state == S_IDLE && req_valid) begin
                r_type <= req_type;
                r_addr <= req_addr;
                r_endp <= req_endp;
                r_tog  <= req_toggle;
            end
            if (fin && !retry) status <= fin_st;
            if (state == S_WAIT_DATA) tog_err <= prx_pid != (r_tog ? PID_DATA1 : PID_DATA0);
            // one-byte holding register lets the final byte be tagged rxd_last once prx_end arrives
            if (state != S_RX_DATA) begin
                bcnt     <= 8'd0;
                buf_full <= 1'b0;
            end else if (!fin) begin
                if (prx_valid) begin
                    rbuf      <= prx_data;
                    buf_full  <= 1'b1;
                    bcnt      <= bcnt + 8'd1;
                    rxd_valid <= buf_full && !tog_err;
                    rxd_data  <= rbuf;
                end else if (prx_end) begin
                    rxd_valid <= buf_full && !tog_err;
                    rxd_last  <= buf_full && !tog_err;
                    rxd_data  <= rbuf;
                end
            end
`ifdef HOSTTRSAC_RETRY_EN
            if (state == S_IDLE && req_valid) retry_cnt <= 2'd0;
            else if (retry) retry_cnt <= retry_cnt + 2'd1;
`endif
        end
endmodule
